center_of_mass: RTL
===================

Name: center_of_mass

Overview:
- Frame-level accumulator that sits directly upstream of compare.
- Sums the (x, y) coordinates and the count of every masked pixel flagged by the colour filter during a frame.
- On the end-of-frame tabulate pulse, snapshots the sums and divides them with a serial restoring divider.
- Emits a one-cycle-valid integer centre of mass (x_out, y_out, valid_out) that feeds compare's x_com_in, y_com_in and com_valid_in.

Parameters:
- H_WIDTH, 320: frame width in pixels; pixels with x_in >= H_WIDTH are ignored.
- V_HEIGHT, 240: frame height in pixels; pixels with y_in >= V_HEIGHT are ignored.
- MIN_PIXELS, 1: minimum in-frame pixel count for a result to be emitted.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  reset, asynchronous, active-high.
- x_in  input  11  column of the current pixel.
- y_in  input  10  row of the current pixel.
- valid_in  input  1  current pixel is in the mask; accumulate it.
- tabulate_in  input  1  single-cycle end-of-frame strobe.
- x_out  output  11  centre-of-mass column.
- y_out  output  10  centre-of-mass row.
- valid_out  output  1  one-cycle strobe marking x_out/y_out as new.
- busy_out  output  1  high while a division is in progress.

Behaviour:
- Internal widths:
  - count: 17 bits.
  - sum_x, sum_y: 25 bits each (319*76800 < 2^25).
  - Divider: 25 iterations, one quotient bit per clock; x and y dividers run in parallel.
- Reset (async assert, sampled deassert):
  - x_out=0, y_out=0, valid_out=0, busy_out=0.
  - All accumulators and snapshots are 0; FSM is in IDLE.
- Accumulation is independent of FSM state and runs every cycle:
  - A pixel is counted only if valid_in=1, x_in<H_WIDTH and y_in<V_HEIGHT.
  - count saturates at 2^17-1; once saturated, further pixels are ignored and sums are held.
- On tabulate_in=1:
  - The current cycle's qualifying pixel is included in the closing frame.
  - Accumulators are cleared to 0 at that edge, so the next frame starts with the following cycle.
- FSM states are IDLE, DIVIDE, DONE.
- IDLE:
  - tabulate_in=1 with final count >= MIN_PIXELS and count != 0: snapshot the sums as dividends and count as divisor, load the iteration counter with 24, go to DIVIDE.
  - tabulate_in=1 with final count < MIN_PIXELS, or count=0: stay in IDLE; no valid_out; x_out/y_out unchanged.
- DIVIDE:
  - busy_out=1.
  - Restoring step per edge, MSB first; the counter decrements.
  - After the step with counter=0, go to DONE.
- DONE:
  - Register x_out = quotient_x[10:0] and y_out = quotient_y[9:0] (floor division).
  - Pulse valid_out=1 for exactly one cycle, then return to IDLE.
- Latency: if tabulate_in is sampled at edge E0, valid_out is high in the cycle after edge E26, i.e. 26 edges later. busy_out is high from E0 to E25.
- Quotients always fit: sum_x/count <= H_WIDTH-1 and sum_y/count <= V_HEIGHT-1.
- tabulate_in while busy_out=1 or in DONE:
  - The result is dropped: no new division starts and the running division is not disturbed.
  - Accumulators are still cleared, which discards that frame's data.
- x_out/y_out hold their last values between valid_out pulses.
- Reset mid-DIVIDE: abort immediately; no valid_out follows.

Test Plan:
- Single pixel (100,50), then tabulate -> valid_out exactly 26 edges later; x_out=100, y_out=50; busy_out high for 26 cycles.
- Four pixels (0,0), (319,0), (0,239), (319,239) -> sums 638/478, count 4 -> x_out=159, y_out=119 (floor).
- MIN_PIXELS=4, three pixels (10,10) then tabulate -> no valid_out; x_out/y_out keep their previous values. Repeat with four pixels -> x_out=10, y_out=10.
- Pixels (320,10) and (5,240) plus (20,30), then tabulate -> out-of-range pixels ignored; x_out=20, y_out=30.
- Second tabulate 10 cycles after a first (first frame pixel (8,6)) -> only one valid_out, with 8/6. Pixel (40,40) driven on the second tabulate cycle is discarded; the next frame with (2,2) yields 2/2.
- Assert rst_in at DIVIDE cycle 12 -> outputs go to 0 asynchronously; no valid_out; a fresh frame with (7,9) then yields 7/9.

Source files
------------

// File: rtl/center_of_mass_if.sv
// Pixel-stream and result bus between the colour filter, center_of_mass and compare.
// The master drives pixels and the frame strobe; the slave returns the centre of mass.
interface center_of_mass_if;
   logic [10:0] x_in;
   logic [9:0]  y_in;
   logic        valid_in;
   logic        tabulate_in;
   logic [10:0] x_out;
   logic [9:0]  y_out;
   logic        valid_out;
   logic        busy_out;

   modport master (
      output x_in, y_in, valid_in, tabulate_in,
      input  x_out, y_out, valid_out, busy_out
   );

   modport slave (
      input  x_in, y_in, valid_in, tabulate_in,
      output x_out, y_out, valid_out, busy_out
   );
endinterface

// File: rtl/center_of_mass.sv
// Frame accumulator for masked pixel coordinates. At end of frame it divides the
// coordinate sums by the pixel count with two parallel serial restoring dividers.
module center_of_mass #(
   parameter int H_WIDTH    = 320,
   parameter int V_HEIGHT   = 240,
   parameter int MIN_PIXELS = 1
) (
   input  logic             clk_in,
   input  logic             rst_in,
   center_of_mass_if.slave  bus
);

   localparam logic [10:0] LP_H_LIMIT = 11'(H_WIDTH);
   localparam logic [9:0]  LP_V_LIMIT = 10'(V_HEIGHT);
   localparam logic [16:0] LP_MIN_CNT = 17'(MIN_PIXELS);
   localparam logic [16:0] LP_CNT_MAX = 17'h1FFFF;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DIVIDE = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   state_t      r_state;
   logic [16:0] r_count;
   logic [24:0] r_sum_x;
   logic [24:0] r_sum_y;
   logic [24:0] r_dvd_x;
   logic [24:0] r_dvd_y;
   logic [16:0] r_rem_x;
   logic [16:0] r_rem_y;
   logic [16:0] r_divisor;
   logic [4:0]  r_iter;
   logic [10:0] r_x_out;
   logic [9:0]  r_y_out;
   logic        r_valid_out;
   logic        r_busy_out;

   logic        w_qual;
   logic        w_start;
   logic [16:0] w_count_fin;
   logic [24:0] w_sum_x_fin;
   logic [24:0] w_sum_y_fin;
   logic [17:0] w_trial_x;
   logic [17:0] w_trial_y;
   logic        w_ge_x;
   logic        w_ge_y;
   logic [16:0] w_rem_x_nxt;
   logic [16:0] w_rem_y_nxt;
   logic [17:0] w_diff_x;
   logic [17:0] w_diff_y;

   // Qualify the current pixel and form the frame totals including it.
   always_comb begin
      w_qual      = bus.valid_in && (bus.x_in < LP_H_LIMIT) && (bus.y_in < LP_V_LIMIT)
                    && (r_count != LP_CNT_MAX);
      w_count_fin = r_count;
      w_sum_x_fin = r_sum_x;
      w_sum_y_fin = r_sum_y;
      if (w_qual) begin
         w_count_fin = r_count + 17'd1;
         w_sum_x_fin = r_sum_x + {14'd0, bus.x_in};
         w_sum_y_fin = r_sum_y + {15'd0, bus.y_in};
      end else begin
         w_count_fin = r_count;
      end
      w_start = bus.tabulate_in && (w_count_fin >= LP_MIN_CNT) && (w_count_fin != 17'd0);
   end

   // One restoring step per divider: shift in the next dividend bit, subtract if it fits.
   always_comb begin
      w_trial_x = {r_rem_x, r_dvd_x[24]};
      w_trial_y = {r_rem_y, r_dvd_y[24]};
      w_diff_x  = w_trial_x - {1'b0, r_divisor};
      w_diff_y  = w_trial_y - {1'b0, r_divisor};
      w_ge_x    = (w_trial_x >= {1'b0, r_divisor});
      w_ge_y    = (w_trial_y >= {1'b0, r_divisor});
      if (w_ge_x) begin
         w_rem_x_nxt = w_diff_x[16:0];
      end else begin
         w_rem_x_nxt = w_trial_x[16:0];
      end
      if (w_ge_y) begin
         w_rem_y_nxt = w_diff_y[16:0];
      end else begin
         w_rem_y_nxt = w_trial_y[16:0];
      end
   end

   // Frame accumulators; cleared on every tabulate regardless of FSM state.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_count <= 17'd0;
         r_sum_x <= 25'd0;
         r_sum_y <= 25'd0;
      end else if (bus.tabulate_in) begin
         r_count <= 17'd0;
         r_sum_x <= 25'd0;
         r_sum_y <= 25'd0;
      end else begin
         r_count <= w_count_fin;
         r_sum_x <= w_sum_x_fin;
         r_sum_y <= w_sum_y_fin;
      end
   end

   // Control FSM with divider datapath; quotient bits shift into the dividend registers.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_state     <= ST_IDLE;
         r_dvd_x     <= 25'd0;
         r_dvd_y     <= 25'd0;
         r_rem_x     <= 17'd0;
         r_rem_y     <= 17'd0;
         r_divisor   <= 17'd0;
         r_iter      <= 5'd0;
         r_x_out     <= 11'd0;
         r_y_out     <= 10'd0;
         r_valid_out <= 1'b0;
         r_busy_out  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_valid_out <= 1'b0;
               if (w_start) begin
                  r_dvd_x    <= w_sum_x_fin;
                  r_dvd_y    <= w_sum_y_fin;
                  r_divisor  <= w_count_fin;
                  r_rem_x    <= 17'd0;
                  r_rem_y    <= 17'd0;
                  r_iter     <= 5'd24;
                  r_busy_out <= 1'b1;
                  r_state    <= ST_DIVIDE;
               end else begin
                  r_busy_out <= 1'b0;
               end
            end
            ST_DIVIDE: begin
               r_valid_out <= 1'b0;
               r_rem_x     <= w_rem_x_nxt;
               r_rem_y     <= w_rem_y_nxt;
               r_dvd_x     <= {r_dvd_x[23:0], w_ge_x};
               r_dvd_y     <= {r_dvd_y[23:0], w_ge_y};
               r_iter      <= r_iter - 5'd1;
               if (r_iter == 5'd0) begin
                  r_state <= ST_DONE;
               end else begin
                  r_state <= ST_DIVIDE;
               end
            end
            ST_DONE: begin
               r_x_out     <= r_dvd_x[10:0];
               r_y_out     <= r_dvd_y[9:0];
               r_valid_out <= 1'b1;
               r_busy_out  <= 1'b0;
               r_state     <= ST_IDLE;
            end
            default: begin
               r_valid_out <= 1'b0;
               r_busy_out  <= 1'b0;
               r_state     <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.x_out     = r_x_out;
   assign bus.y_out     = r_y_out;
   assign bus.valid_out = r_valid_out;
   assign bus.busy_out  = r_busy_out;

endmodule
